// File: rtl/spr_pixel_mux.sv
// rtl/spr_pixel_mux.sv - per-scanline sprite shifters and final sprite/background priority mux
module spr_pixel_mux (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] cycleNum,
  input  logic       load_v,
  input  logic [2:0] load_slot,
  input  logic       load_valid,
  input  logic       load_spr0,
  input  logic [7:0] load_lo,
  input  logic [7:0] load_hi,
  input  logic [7:0] load_x,
  input  logic [7:0] load_attr,
  input  logic [3:0] bg_pixel,
  input  logic       show_bg,
  input  logic       show_spr,
  input  logic       show_left_bg,
  input  logic       show_left_spr,
  input  logic       spr0_clear,
  output logic [4:0] pix_out,
  output logic       pix_v,
  output logic       spr0_hit
);

  // Per-slot state: two pattern shifters, X down-counter and attributes.
  logic [7:0][7:0] shift_lo;
  logic [7:0][7:0] shift_hi;
  logic [7:0][7:0] counter;
  logic [7:0][1:0] pal;
  logic [7:0]      behind;
  logic [7:0]      valid;
  logic [7:0]      spr0;

  logic       in_vis;
  logic       in_load;
  logic [7:0] x;
  logic       x_left;

  logic       win_found;
  logic [1:0] win_pat;
  logic [1:0] win_pal;
  logic       win_behind;
  logic       spr0_cand;

  logic       spr_ok;
  logic       bg_ok;
  logic       spr_opaque;
  logic       hit;
  logic [4:0] mux_pix;

  // Attribute bits other than priority and palette are not needed here.
  logic       unused_attr;
  assign unused_attr = ^{load_attr[7:6], load_attr[4:2]};

  assign in_vis  = (cycleNum >= 9'd1)   && (cycleNum <= 9'd256);
  assign in_load = (cycleNum >= 9'd257) && (cycleNum <= 9'd320);
  assign x       = 8'(cycleNum - 9'd1);
  assign x_left  = (x < 8'd8);

  // Find the lowest-index active slot with an opaque pattern bit; any active
  // opaque sprite-0 slot is a hit candidate regardless of which slot wins.
  always_comb begin
    win_found  = 1'b0;
    win_pat    = 2'b00;
    win_pal    = 2'b00;
    win_behind = 1'b0;
    spr0_cand  = 1'b0;
    for (int s = 7; s >= 0; s--) begin
      if (valid[3'(s)] && (counter[3'(s)] == 8'd0) &&
          ({shift_hi[3'(s)][7], shift_lo[3'(s)][7]} != 2'b00)) begin
        win_found  = 1'b1;
        win_pat    = {shift_hi[3'(s)][7], shift_lo[3'(s)][7]};
        win_pal    = pal[3'(s)];
        win_behind = behind[3'(s)];
        if (spr0[3'(s)]) begin
          spr0_cand = 1'b1;
        end
      end
    end
  end

  assign spr_ok     = show_spr && (!x_left || show_left_spr);
  assign bg_ok      = show_bg && (bg_pixel[1:0] != 2'b00) && (!x_left || show_left_bg);
  assign spr_opaque = win_found && spr_ok;
  assign hit        = in_vis && spr0_cand && spr_ok && bg_ok && (x != 8'd255);

  // Priority mux between the winning sprite pixel, the background and backdrop.
  always_comb begin
    mux_pix = 5'd0;
    if (spr_opaque && (!bg_ok || !win_behind)) begin
      mux_pix = {1'b1, win_pal, win_pat};
    end else if (bg_ok) begin
      mux_pix = {1'b0, bg_pixel};
    end
  end

  // Slot loading, per-dot counting/shifting, output register and sticky hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_lo <= '0;
      shift_hi <= '0;
      counter  <= '0;
      pal      <= '0;
      behind   <= '0;
      valid    <= '0;
      spr0     <= '0;
      pix_out  <= 5'd0;
      pix_v    <= 1'b0;
      spr0_hit <= 1'b0;
    end else begin
      if (in_vis) begin
        pix_v   <= 1'b1;
        pix_out <= mux_pix;
        for (int s = 0; s < 8; s++) begin
          if (counter[3'(s)] != 8'd0) begin
            counter[3'(s)] <= counter[3'(s)] - 8'd1;
          end else begin
            shift_lo[3'(s)] <= {shift_lo[3'(s)][6:0], 1'b0};
            shift_hi[3'(s)] <= {shift_hi[3'(s)][6:0], 1'b0};
          end
        end
      end else begin
        pix_v <= 1'b0;
      end

      if (spr0_clear) begin
        spr0_hit <= 1'b0;
      end else if (hit) begin
        spr0_hit <= 1'b1;
      end

      if (cycleNum == 9'd257) begin
        valid <= '0;
      end
      if (in_load && load_v) begin
        valid[load_slot]    <= load_valid;
        spr0[load_slot]     <= load_spr0;
        shift_lo[load_slot] <= load_lo;
        shift_hi[load_slot] <= load_hi;
        counter[load_slot]  <= load_x;
        pal[load_slot]      <= load_attr[1:0];
        behind[load_slot]   <= load_attr[5];
      end
    end
  end

endmodule

// File: tb/tb_spr_pixel_mux.sv
// tb/tb_spr_pixel_mux.sv - self-checking bench for spr_pixel_mux
module tb_spr_pixel_mux;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] cycleNum;
  logic       load_v;
  logic [2:0] load_slot;
  logic       load_valid;
  logic       load_spr0;
  logic [7:0] load_lo;
  logic [7:0] load_hi;
  logic [7:0] load_x;
  logic [7:0] load_attr;
  logic [3:0] bg_pixel;
  logic       show_bg;
  logic       show_spr;
  logic       show_left_bg;
  logic       show_left_spr;
  logic       spr0_clear;
  logic [4:0] pix_out;
  logic       pix_v;
  logic       spr0_hit;

  spr_pixel_mux dut (
    .clock(clock), .reset(reset), .cycleNum(cycleNum),
    .load_v(load_v), .load_slot(load_slot), .load_valid(load_valid),
    .load_spr0(load_spr0), .load_lo(load_lo), .load_hi(load_hi),
    .load_x(load_x), .load_attr(load_attr), .bg_pixel(bg_pixel),
    .show_bg(show_bg), .show_spr(show_spr), .show_left_bg(show_left_bg),
    .show_left_spr(show_left_spr), .spr0_clear(spr0_clear),
    .pix_out(pix_out), .pix_v(pix_v), .spr0_hit(spr0_hit)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: sprites described by screen geometry, not counters.
  bit         m_valid[8];
  int         m_x[8];
  logic [7:0] m_lo[8];
  logic [7:0] m_hi[8];
  logic [1:0] m_pal[8];
  bit         m_beh[8];
  bit         m_s0[8];
  logic [4:0] m_pix;
  logic       m_v;
  logic       m_hit;

  // Per-line stimulus configuration.
  bit         cfg_en[8];
  bit         cfg_valid[8];
  bit         cfg_spr0[8];
  logic [7:0] cfg_lo[8];
  logic [7:0] cfg_hi[8];
  logic [7:0] cfg_x[8];
  logic [7:0] cfg_attr[8];
  int         rst_dot = -1;
  int         clr_dot = -1;
  int         extra_dot = -1;
  bit         rnd_mode = 0;
  logic [3:0] bg_fixed = 4'd0;

  typedef struct {
    int dot;
    int pix;
    int hit;
    string name;
  } chk_t;
  chk_t chk_q[$];

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] x;
    logic [7:0] attr;
    logic [3:0] bg;
    logic [3:0] shows;
    int         dot;
    logic [4:0] pix;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model_step();
    int x, off;
    bit found, s0, spr_ok, bg_ok;
    logic [1:0] p, wpat, wpal;
    bit wbeh;
    if (reset) begin
      for (int s = 0; s < 8; s++) m_valid[s] = 0;
      m_pix = 5'd0;
      m_v   = 1'b0;
      m_hit = 1'b0;
      return;
    end
    if (cycleNum >= 1 && cycleNum <= 256) begin
      x = int'(cycleNum) - 1;
      found = 0; s0 = 0; wpat = 0; wpal = 0; wbeh = 0;
      for (int s = 0; s < 8; s++) begin
        if (m_valid[s] && x >= m_x[s] && x - m_x[s] < 8) begin
          off = x - m_x[s];
          p = {m_hi[s][7-off], m_lo[s][7-off]};
          if (p != 2'b00) begin
            if (!found) begin
              found = 1; wpat = p; wpal = m_pal[s]; wbeh = m_beh[s];
            end
            if (m_s0[s]) s0 = 1;
          end
        end
      end
      spr_ok = show_spr && (x >= 8 || show_left_spr);
      bg_ok  = show_bg && bg_pixel[1:0] != 2'b00 && (x >= 8 || show_left_bg);
      if (found && spr_ok && (!bg_ok || !wbeh)) m_pix = {1'b1, wpal, wpat};
      else if (bg_ok) m_pix = {1'b0, bg_pixel};
      else m_pix = 5'd0;
      m_v = 1'b1;
      if (s0 && spr_ok && bg_ok && x != 255) m_hit = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    if (spr0_clear) m_hit = 1'b0;
    if (cycleNum == 257) for (int s = 0; s < 8; s++) m_valid[s] = 0;
    if (cycleNum >= 257 && cycleNum <= 320 && load_v) begin
      m_valid[load_slot] = load_valid;
      m_s0[load_slot]    = load_spr0;
      m_lo[load_slot]    = load_lo;
      m_hi[load_slot]    = load_hi;
      m_x[load_slot]     = int'(load_x);
      m_pal[load_slot]   = load_attr[1:0];
      m_beh[load_slot]   = load_attr[5];
    end
  endtask

  task automatic step();
    int c;
    c = int'(cycleNum);
    model_step();
    @(posedge clock);
    #1;
    checks++;
    if (pix_out !== m_pix || pix_v !== m_v || spr0_hit !== m_hit) begin
      errors++;
      $display("FAIL model cyc=%0d rst=%b: got pix=%h v=%b hit=%b, want pix=%h v=%b hit=%b",
               c, reset, pix_out, pix_v, spr0_hit, m_pix, m_v, m_hit);
    end
  endtask

  task automatic drive_slot(input int s);
    load_v     = 1'b1;
    load_slot  = 3'(s);
    load_valid = cfg_valid[s];
    load_spr0  = cfg_spr0[s];
    load_lo    = cfg_lo[s];
    load_hi    = cfg_hi[s];
    load_x     = cfg_x[s];
    load_attr  = cfg_attr[s];
  endtask

  task automatic run_line();
    for (int c = 0; c <= 340; c++) begin
      cycleNum   = 9'(c);
      reset      = (c == rst_dot);
      spr0_clear = (c == clr_dot);
      load_v     = 1'b0;
      if (c >= 258 && c <= 265 && cfg_en[c-258]) begin
        drive_slot(c - 258);
      end else if (c == extra_dot) begin
        drive_slot(0);
      end else if (rnd_mode && (c < 257 || c > 320) && $urandom_range(0, 19) == 0) begin
        load_v = 1'b1; load_slot = 3'($urandom); load_valid = 1'b1;
        load_spr0 = 1'b1; load_lo = 8'hFF; load_hi = 8'hFF;
        load_x = 8'($urandom); load_attr = 8'($urandom);
      end
      bg_pixel = rnd_mode ? 4'($urandom) : bg_fixed;
      step();
      foreach (chk_q[i]) begin
        if (chk_q[i].dot == c) begin
          if (chk_q[i].pix >= 0) check({chk_q[i].name, " pix"}, int'(pix_out), chk_q[i].pix);
          if (chk_q[i].hit >= 0) check({chk_q[i].name, " hit"}, int'(spr0_hit), chk_q[i].hit);
        end
      end
    end
    chk_q.delete();
  endtask

  task automatic clear_cfg();
    for (int s = 0; s < 8; s++) begin
      cfg_en[s] = 0; cfg_valid[s] = 1; cfg_spr0[s] = 0;
      cfg_lo[s] = 8'h00; cfg_hi[s] = 8'h00; cfg_x[s] = 8'h00; cfg_attr[s] = 8'h00;
    end
  endtask

  task automatic set_slot(input int s, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] x, input logic [7:0] attr, input bit s0);
    cfg_en[s] = 1; cfg_valid[s] = 1; cfg_spr0[s] = s0;
    cfg_lo[s] = lo; cfg_hi[s] = hi; cfg_x[s] = x; cfg_attr[s] = attr;
  endtask

  task automatic do_reset();
    reset = 1'b1; cycleNum = 9'd0; load_v = 1'b0; spr0_clear = 1'b0;
    step();
    step();
    reset = 1'b0;
    show_bg = 1; show_spr = 1; show_left_bg = 1; show_left_spr = 1;
    rst_dot = -1; clr_dot = -1; extra_dot = -1; bg_fixed = 4'd0;
    clear_cfg();
  endtask

  task automatic push_chk(input int dot, input int pix, input int hit, input string name);
    chk_t k;
    k.dot = dot; k.pix = pix; k.hit = hit; k.name = name;
    chk_q.push_back(k);
  endtask

  initial begin
    reset = 1; cycleNum = 0; load_v = 0; load_slot = 0; load_valid = 0; load_spr0 = 0;
    load_lo = 0; load_hi = 0; load_x = 0; load_attr = 0; bg_pixel = 0;
    show_bg = 1; show_spr = 1; show_left_bg = 1; show_left_spr = 1; spr0_clear = 0;
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 0; m_x[s] = 0; m_lo[s] = 0; m_hi[s] = 0; m_pal[s] = 0; m_beh[s] = 0; m_s0[s] = 0;
    end
    m_pix = 0; m_v = 0; m_hit = 0;
    do_reset();
    check("reset pix_out", int'(pix_out), 0);
    check("reset pix_v", int'(pix_v), 0);
    check("reset spr0_hit", int'(spr0_hit), 0);

    // {lo, hi, x, attr, bg, {show_bg,show_spr,show_left_bg,show_left_spr}, dot, pix}
    vecs.push_back('{8'hFF, 8'h00, 8'd10,  8'h01, 4'h0, 4'hF,    11,  5'h15});
    vecs.push_back('{8'hFF, 8'h00, 8'd10,  8'h01, 4'h0, 4'hF,    18,  5'h15});
    vecs.push_back('{8'hFF, 8'h00, 8'd10,  8'h01, 4'h0, 4'hF,    19,  5'h00});
    vecs.push_back('{8'hFF, 8'h00, 8'd10,  8'h01, 4'h0, 4'hF,    10,  5'h00});
    vecs.push_back('{8'hFF, 8'hFF, 8'd50,  8'h22, 4'h6, 4'hF,    51,  5'h06});
    vecs.push_back('{8'hFF, 8'hFF, 8'd50,  8'h22, 4'h4, 4'hF,    51,  5'h1B});
    vecs.push_back('{8'hFF, 8'hFF, 8'd50,  8'h02, 4'h6, 4'hF,    51,  5'h1B});
    vecs.push_back('{8'hFF, 8'h00, 8'd3,   8'h00, 4'h0, 4'b1110, 4,   5'h00});
    vecs.push_back('{8'hFF, 8'h00, 8'd100, 8'h00, 4'h7, 4'b1101, 4,   5'h00});
    vecs.push_back('{8'hFF, 8'h00, 8'd100, 8'h00, 4'hB, 4'hF,    201, 5'h0B});
    vecs.push_back('{8'h80, 8'h80, 8'd255, 8'h03, 4'h0, 4'hF,    256, 5'h1F});
    vecs.push_back('{8'h80, 8'h00, 8'd0,   8'h00, 4'h0, 4'hF,    1,   5'h11});
    vecs.push_back('{8'hFF, 8'h00, 8'd10,  8'h01, 4'h0, 4'b1011, 12,  5'h00});

    foreach (vecs[i]) begin
      do_reset();
      set_slot(0, vecs[i].lo, vecs[i].hi, vecs[i].x, vecs[i].attr, 0);
      {show_bg, show_spr, show_left_bg, show_left_spr} = vecs[i].shows;
      bg_fixed = vecs[i].bg;
      run_line();
      cfg_en[0] = 0;
      push_chk(vecs[i].dot, int'(vecs[i].pix), -1, $sformatf("vec%0d", i));
      run_line();
    end

    // Overlapping slots: lowest index wins, then the lower slot goes transparent.
    do_reset();
    set_slot(2, 8'h00, 8'h80, 8'd20, 8'h03, 0);
    set_slot(5, 8'h80, 8'h00, 8'd20, 8'h00, 0);
    run_line();
    cfg_hi[2] = 8'h00;
    push_chk(21, 5'h1E, -1, "overlap slot2");
    run_line();
    push_chk(21, 5'h11, -1, "overlap slot5");
    run_line();

    // Sprite-0 hit at x=255 is suppressed.
    do_reset();
    bg_fixed = 4'h1;
    set_slot(0, 8'hFF, 8'h00, 8'd255, 8'h00, 1);
    run_line();
    cfg_en[0] = 0;
    push_chk(256, 5'h11, 0, "hit x255");
    push_chk(340, -1, 0, "hit x255 eol");
    run_line();

    // Sprite-0 hit at x=100 rises with the dot-101 pixel and stays set.
    do_reset();
    bg_fixed = 4'h1;
    set_slot(0, 8'hFF, 8'h00, 8'd100, 8'h00, 1);
    run_line();
    cfg_en[0] = 0;
    push_chk(100, -1, 0, "hit before");
    push_chk(101, 5'h11, 1, "hit rise");
    push_chk(340, -1, 1, "hit sticky");
    run_line();

    // Left-edge sprite masking blocks the hit.
    do_reset();
    bg_fixed = 4'h1;
    show_left_spr = 0;
    set_slot(0, 8'hF0, 8'h00, 8'd3, 8'h00, 1);
    run_line();
    cfg_en[0] = 0;
    push_chk(340, -1, 0, "hit left mask");
    run_line();

    // Clear and hit on the same dot: clear wins.
    do_reset();
    bg_fixed = 4'h1;
    set_slot(0, 8'h80, 8'h00, 8'd100, 8'h00, 1);
    run_line();
    cfg_en[0] = 0;
    clr_dot = 101;
    push_chk(101, -1, 0, "clear vs hit");
    push_chk(340, -1, 0, "clear vs hit eol");
    run_line();

    // Load outside the window is ignored.
    do_reset();
    set_slot(0, 8'hFF, 8'h00, 8'd10, 8'h01, 0);
    cfg_en[0] = 0;
    extra_dot = 200;
    run_line();
    extra_dot = -1;
    push_chk(11, 5'h00, -1, "late load ignored");
    run_line();

    // A slot not reloaded after dot 257 is dropped.
    do_reset();
    set_slot(0, 8'hFF, 8'h00, 8'd10, 8'h01, 0);
    run_line();
    cfg_en[0] = 0;
    push_chk(11, 5'h15, -1, "loaded renders");
    run_line();
    push_chk(11, 5'h00, -1, "stale slot silent");
    run_line();

    // Reset in the middle of a sprite.
    do_reset();
    set_slot(0, 8'hFF, 8'h00, 8'd145, 8'h01, 0);
    run_line();
    cfg_en[0] = 0;
    rst_dot = 150;
    push_chk(149, 5'h15, -1, "pre reset");
    push_chk(150, 5'h00, 0, "at reset");
    push_chk(152, 5'h00, -1, "post reset");
    run_line();
    rst_dot = -1;
    check("pix_v after line", int'(pix_v), 0);

    // Randomized lines checked against the geometric model.
    do_reset();
    rnd_mode = 1;
    for (int l = 0; l < 30; l++) begin
      for (int s = 0; s < 8; s++) begin
        cfg_en[s]    = ($urandom_range(0, 3) != 0);
        cfg_valid[s] = ($urandom_range(0, 7) != 0);
        cfg_spr0[s]  = ($urandom_range(0, 3) == 0);
        cfg_lo[s]    = 8'($urandom);
        cfg_hi[s]    = 8'($urandom);
        cfg_x[s]     = 8'($urandom);
        cfg_attr[s]  = 8'($urandom);
      end
      show_bg       = ($urandom_range(0, 7) != 0);
      show_spr      = ($urandom_range(0, 7) != 0);
      show_left_bg  = ($urandom_range(0, 3) != 0);
      show_left_spr = ($urandom_range(0, 3) != 0);
      clr_dot = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 340)) : -1;
      rst_dot = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 340)) : -1;
      run_line();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spr_pixel_mux.md
# spr_pixel_mux

Per-scanline sprite output stage and final pixel priority multiplexer. Sits directly downstream of the sprite engine: during the sprite-fetch window (dots 257–320) it accepts up to eight fetched sprite slots (pattern bytes, X, attributes). During the next visible span (dots 1–256) it counts down each slot's X, shifts out pattern bits, and merges the winning sprite pixel with the background pixel. It produces a 5-bit palette index per dot and the sticky sprite-0 hit flag.

## Interface
Parameters: none.

- clock  in  1  system clock; one dot per cycle
- reset  in  1  synchronous, active-high reset
- cycleNum  in  9  current dot within the scanline, 0–340
- load_v  in  1  slot load strobe from the sprite engine
- load_slot  in  3  slot index written by load_v
- load_valid  in  1  slot holds a real in-range sprite
- load_spr0  in  1  slot holds primary-OAM sprite 0
- load_lo  in  8  pattern low plane, already X-flipped upstream
- load_hi  in  8  pattern high plane, already X-flipped upstream
- load_x  in  8  sprite X coordinate
- load_attr  in  8  OAM attribute byte; [5]=behind-background, [1:0]=palette
- bg_pixel  in  4  background {palette[1:0], pattern[1:0]} for the current dot
- show_bg  in  1  background enable
- show_spr  in  1  sprite enable
- show_left_bg  in  1  background enable for x<8
- show_left_spr  in  1  sprite enable for x<8
- spr0_clear  in  1  clears spr0_hit (pre-render line, dot 1)
- pix_out  out  5  palette RAM index: {1, pal, pat} sprite, {0, pal, pat} background, 0 backdrop
- pix_v  out  1  pix_out valid for the dot evaluated on the previous cycle
- spr0_hit  out  1  sticky sprite-0 hit flag

## Operation
- Per slot s (0–7): shift_lo[s], shift_hi[s], counter[s] (8b), pal[s] (2b), behind[s], valid[s], spr0[s].
- Load window, cycleNum 257–320:
  - On load_v, slot load_slot takes all load_* fields.
  - On cycleNum==257 every valid[s] is cleared first; a load in the same cycle still takes effect for its slot.
  - load_v outside 257–320 is ignored.
- Visible window, cycleNum 1–256, pixel x = cycleNum−1. Evaluate from current register state, then update.
  - Slot s is active when valid[s] and counter[s]==0; its pattern is {shift_hi[s][7], shift_lo[s][7]}.
  - The sprite pixel comes from the lowest-index active slot with nonzero pattern. If none, the sprite pixel is transparent.
  - Update: if counter[s]!=0, decrement it. Otherwise shift both shifters left, zero-filling, so they are transparent after 8 shifts.
- Transparency/masking:
  - Background is opaque iff show_bg, bg_pixel[1:0]!=0, and (x>=8 or show_left_bg).
  - Sprite is opaque iff show_spr, pattern!=0, and (x>=8 or show_left_spr).
- Mux:
  - Neither opaque → 5'd0.
  - Background only → {0, bg_pixel}.
  - Sprite only → {1, pal, pat}.
  - Both opaque → sprite when behind=0, background when behind=1.
- Sprite-0 hit sets when all of the following hold:
  - a slot with spr0=1 is active with nonzero pattern and passes sprite masking;
  - background is opaque;
  - x!=255.
  - Priority bits and which slot wins the mux do not affect the hit.
- spr0_hit clears only on spr0_clear or reset. If spr0_clear and a hit occur in the same cycle, the clear wins.

## Timing
- Reset values: pix_out=0, pix_v=0, spr0_hit=0. All valid, counter, shifter, pal, behind and spr0 registers are 0.
- Latency is 1 cycle: the dot evaluated while cycleNum==d appears on pix_out/pix_v in the following cycle.
- pix_v=1 exactly in the cycles after cycleNum 1–256, otherwise 0. pix_out holds its last value when pix_v=0.
- spr0_hit rises in the same cycle as the pix_out for the hitting dot.
- Slot-load writes are visible on the next cycle. No load-to-render hazard exists because the windows are disjoint.
- X=0: the sprite is visible at dot 1 (x=0). X=255: only x=255 is visible; the rest is clipped at end of line.
- Reset mid-line: all state zeroes immediately. Output is backdrop/background only until the next load window.
- cycleNum 0 and 321–340: no counter, shifter or output activity.

## Test plan
- Load slot 0: lo=0xFF, hi=0x00, x=10, attr=0x01, valid. bg transparent, all show_* enables=1 → pix_out=5'b1_01_01 for x=10–17, 0 elsewhere. pix_v is high for 256 cycles.
- Slot 2 (x=20, pat 2, pal 3) overlaps slot 5 (x=20, pat 1) → x=20 gives {1,11,10}. Then clear slot 2's pattern bit → slot 5 shows.
- Behind-priority: sprite attr[5]=1, bg_pixel=4'b0110 at the same x → pix_out=5'b0_0110. With bg_pixel=4'b0100 (transparent) → sprite pixel shown.
- Sprite-0 hit: spr0 slot at x=255 with opaque bg → no hit. Same sprite at x=100 → hit rises after dot 101. Set show_left_spr=0 with x=3 → no hit. spr0_clear and a hit in the same cycle → flag stays 0.
- Load-window rules: load_v at cycleNum=200 is ignored. A slot loaded at the previous line's 260 but not reloaded after 257 renders nothing.
- Assert reset at cycleNum=150 mid-sprite → next-cycle outputs are 0, and the slot stays silent for the rest of the line.
